// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
// Registers the controller's six light requests onto the lamp drives, with one
// cycle of latency. It checks the request stream for unsafe patterns. On a
// violation it latches a fault and forces both red lamps to flash together.
// An operator clear returns the block through a steady all-red interval.
// Optional build macro: TRAFFIC_LAMP_MONITOR_AUTO_RECOVER_EN. When defined, the
// block also leaves FAULT on its own after RECOVER_CYC cycles.
// Handshake: none; every input is sampled on each rising clk edge.
module traffic_lamp_monitor #(
    parameter int CONFLICT_PERSIST = 2,
    parameter int MIN_YELLOW       = 3,
    parameter int FLASH_HALF       = 32,
    parameter int ALLRED_CYC       = 16,
    parameter int RECOVER_CYC      = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_green,
    input  logic       ns_yellow,
    input  logic       ns_red,
    input  logic       ew_green,
    input  logic       ew_yellow,
    input  logic       ew_red,
    input  logic       fault_clr,
    output logic       lamp_ns_g,
    output logic       lamp_ns_y,
    output logic       lamp_ns_r,
    output logic       lamp_ew_g,
    output logic       lamp_ew_y,
    output logic       lamp_ew_r,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count
);

    localparam int AW = $clog2(ALLRED_CYC + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int PW = $clog2(CONFLICT_PERSIST + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam int DW = $clog2(RECOVER_CYC + 1);
    localparam logic [AW-1:0] AR_LAST = AW'(ALLRED_CYC - 1);
    localparam logic [YW-1:0] MIN_Y   = YW'(MIN_YELLOW);
    localparam logic [FW-1:0] FH_LAST = FW'(FLASH_HALF - 1);

    // Every timing parameter must be at least one cycle.
    if (CONFLICT_PERSIST < 1 || MIN_YELLOW < 1 || FLASH_HALF < 1 ||
        ALLRED_CYC < 1 || RECOVER_CYC < 1 || DW < 1) begin : g_bad_param
        $error("traffic_lamp_monitor: timing parameters must be >= 1");
    end

    typedef enum logic [1:0] {ALL_RED = 2'd0, MON = 2'd1, FAULT = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [2:0]      code_nxt;
    logic [2:0]      ns_in, ew_in, prev_ns, prev_ew;
    logic [AW-1:0]   allred_cnt;
    logic [YW-1:0]   yrun_ns, yrun_ew;
    logic [PW-1:0]   persist_cnt;
    logic [FW-1:0]   flash_cnt, flash_cnt_nxt;
    logic            flash_on, flash_on_nxt;
    logic [5:0]      lamps, lamp_nxt;
    logic            ns_ok, ew_ok, conflict, encoding, static_bad, persist_hit;
    logic            skipped, short_y, legal;

    assign ns_in = {ns_green, ns_yellow, ns_red};
    assign ew_in = {ew_green, ew_yellow, ew_red};

    // Static checks look at the current requests only.
    assign ns_ok       = $onehot(ns_in);
    assign ew_ok       = $onehot(ew_in);
    assign conflict    = !ns_red && !ew_red;
    assign encoding    = !ns_ok || !ew_ok;
    assign static_bad  = conflict || encoding;
    assign persist_hit = static_bad && (int'(persist_cnt) + 1 >= CONFLICT_PERSIST);
    assign legal       = ns_ok && ew_ok && (ns_red || ew_red);

    // A green that disappears without turning yellow counts as a skipped yellow.
    // This also catches green going dark.
    assign skipped = (prev_ns[2] && !ns_green && !ns_yellow) ||
                     (prev_ew[2] && !ew_green && !ew_yellow);
    assign short_y = (prev_ns[1] && !ns_yellow && (yrun_ns < MIN_Y)) ||
                     (prev_ew[1] && !ew_yellow && (yrun_ew < MIN_Y));

`ifdef TRAFFIC_LAMP_MONITOR_AUTO_RECOVER_EN
    localparam logic [DW-1:0] RC_LAST = DW'(RECOVER_CYC - 1);
    logic [DW-1:0] dwell_cnt;

    // Count the cycles spent in FAULT, for the automatic exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dwell_cnt <= '0;
        else if (state != FAULT) dwell_cnt <= '0;
        else dwell_cnt <= dwell_cnt + 1'b1;
    end
`endif

    // Compute the next state, and the fault cause when entering FAULT.
    // Priority: conflict > encoding > skipped yellow > short yellow.
    always_comb begin
        state_nxt = state;
        code_nxt  = fault_code;
        case (state)
            ALL_RED: if (allred_cnt == AR_LAST && legal) state_nxt = MON;
            MON: begin
                if (persist_hit) begin
                    state_nxt = FAULT;
                    code_nxt  = conflict ? 3'd2 : 3'd1;
                end else if (skipped) begin
                    state_nxt = FAULT;
                    code_nxt  = 3'd3;
                end else if (short_y) begin
                    state_nxt = FAULT;
                    code_nxt  = 3'd4;
                end
            end
            FAULT: begin
                if (fault_clr) state_nxt = ALL_RED;
`ifdef TRAFFIC_LAMP_MONITOR_AUTO_RECOVER_EN
                else if (dwell_cnt == RC_LAST) state_nxt = ALL_RED;
`endif
            end
            default: state_nxt = ALL_RED;
        endcase
    end

    // Flash phase: ON in the first FAULT cycle, then toggles every FLASH_HALF cycles.
    always_comb begin
        flash_cnt_nxt = '0;
        flash_on_nxt  = 1'b1;
        if (state == FAULT && state_nxt == FAULT) begin
            if (flash_cnt == FH_LAST) begin
                flash_on_nxt = !flash_on;
            end else begin
                flash_cnt_nxt = flash_cnt + 1'b1;
                flash_on_nxt  = flash_on;
            end
        end
    end

    // Lamp values for the coming cycle follow the state being entered.
    always_comb begin
        lamp_nxt = 6'b001_001;
        case (state_nxt)
            MON:     lamp_nxt = {ns_in, ew_in};
            FAULT:   lamp_nxt = {2'b00, flash_on_nxt, 2'b00, flash_on_nxt};
            default: lamp_nxt = 6'b001_001;
        endcase
    end

    // State register, lamp drives and fault bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ALL_RED;
            lamps       <= 6'b001_001;
            flash_cnt   <= '0;
            flash_on    <= 1'b1;
            fault_code  <= 3'd0;
            fault_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            lamps     <= lamp_nxt;
            flash_cnt <= flash_cnt_nxt;
            flash_on  <= flash_on_nxt;
            if (state != FAULT && state_nxt == FAULT) begin
                fault_code <= code_nxt;
                if (fault_count != 8'hFF) fault_count <= fault_count + 1'b1;
            end
        end
    end

    // All-red dwell counter and static-violation persistence counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            allred_cnt  <= '0;
            persist_cnt <= '0;
        end else begin
            if (state != ALL_RED) allred_cnt <= '0;
            else if (allred_cnt != AR_LAST) allred_cnt <= allred_cnt + 1'b1;
            if (state == MON && static_bad && !persist_hit) persist_cnt <= persist_cnt + 1'b1;
            else persist_cnt <= '0;
        end
    end

    // Previous requests and yellow run lengths feed the transition checks.
    // In ALL_RED these registers track the live requests, so they hold
    // matching values when MON begins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ns <= 3'b000;
            prev_ew <= 3'b000;
            yrun_ns <= '0;
            yrun_ew <= '0;
        end else begin
            prev_ns <= ns_in;
            prev_ew <= ew_in;
            if (state == ALL_RED) begin
                yrun_ns <= YW'(ns_yellow);
                yrun_ew <= YW'(ew_yellow);
            end else begin
                if (!ns_yellow) yrun_ns <= '0;
                else if (yrun_ns != MIN_Y) yrun_ns <= yrun_ns + 1'b1;
                if (!ew_yellow) yrun_ew <= '0;
                else if (yrun_ew != MIN_Y) yrun_ew <= yrun_ew + 1'b1;
            end
        end
    end

    assign {lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r} = lamps;
    assign fault = (state == FAULT);

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor.
// Expected values are worked out by hand from the block's timing:
// 16 all-red cycles, one cycle of lamp latency, and a 64-cycle flash period.
module tb_traffic_lamp_monitor;

    localparam logic [2:0] G   = 3'b100;
    localparam logic [2:0] Y   = 3'b010;
    localparam logic [2:0] R   = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red;
    logic       fault_clr;
    logic       lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;
    logic [5:0] lamps;

    int checks = 0;
    int errors = 0;

    traffic_lamp_monitor dut (
        .clk(clk), .rst(rst),
        .ns_green(ns_green), .ns_yellow(ns_yellow), .ns_red(ns_red),
        .ew_green(ew_green), .ew_yellow(ew_yellow), .ew_red(ew_red),
        .fault_clr(fault_clr),
        .lamp_ns_g(lamp_ns_g), .lamp_ns_y(lamp_ns_y), .lamp_ns_r(lamp_ns_r),
        .lamp_ew_g(lamp_ew_g), .lamp_ew_y(lamp_ew_y), .lamp_ew_r(lamp_ew_r),
        .fault(fault), .fault_code(fault_code), .fault_count(fault_count)
    );

    assign lamps = {lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r};

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] ns, input logic [2:0] ew);
        {ns_green, ns_yellow, ns_red} = ns;
        {ew_green, ew_yellow, ew_red} = ew;
    endtask

    // Apply a legal MON step: the lamps must show it after the edge, with no fault.
    task automatic drive(input logic [2:0] ns, input logic [2:0] ew);
        set_in(ns, ew);
        tick();
        chk("pass_lamps", 32'(lamps), 32'({ns, ew}));
        chk("pass_fault", 32'(fault), 32'd0);
    endtask

    // Clear the fault, then sit out the all-red interval with red requests.
    task automatic recover();
        fault_clr = 1'b1;
        set_in(R, R);
        tick();
        fault_clr = 1'b0;
        chk("clr_fault", 32'(fault), 32'd0);
        repeat (16) tick();
    endtask

    initial begin
        rst = 1'b1;
        fault_clr = 1'b0;
        set_in(R, R);
        #1;
        chk("rst_lamps", 32'(lamps), 32'b001001);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_code", 32'(fault_code), 32'd0);
        chk("rst_count", 32'(fault_count), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        set_in(G, R);

        // all-red interval after reset, then pass-through
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("allred_lamps", 32'(lamps), 32'b001001);
        end
        tick();
        chk("mon_entry_lamps", 32'(lamps), 32'b100001);

        // two full rotations per direction
        for (int r = 0; r < 2; r++) begin
            repeat (64) drive(G, R);
            repeat (5)  drive(Y, R);
            repeat (64) drive(R, G);
            repeat (5)  drive(R, Y);
        end
        chk("rot_count", 32'(fault_count), 32'd0);

        // one-cycle conflict while NS yellow finishes: tolerated
        drive(G, R);
        drive(Y, R);
        drive(Y, R);
        drive(Y, G);
        drive(R, G);

        // two-cycle conflict faults; clear held on the entry edge is ignored
        set_in(G, G);
        tick();
        chk("conf1_lamps", 32'(lamps), 32'b100100);
        chk("conf1_fault", 32'(fault), 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("conf2_fault", 32'(fault), 32'd1);
        chk("conf2_code", 32'(fault_code), 32'd2);
        chk("conf2_count", 32'(fault_count), 32'd1);
        chk("flash_first", 32'(lamps), 32'b001001);
        for (int k = 1; k <= 70; k++) begin
            tick();
            chk("flash_lamps", 32'(lamps), ((k / 32) % 2 == 0) ? 32'b001001 : 32'b000000);
        end
        chk("flash_fault_hold", 32'(fault), 32'd1);

        // operator clear: all-red interval, code retained
        fault_clr = 1'b1;
        set_in(R, R);
        tick();
        fault_clr = 1'b0;
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_code", 32'(fault_code), 32'd2);
        chk("clr_count", 32'(fault_count), 32'd1);
        chk("clr_lamps", 32'(lamps), 32'b001001);
        set_in(G, R);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("clr_allred", 32'(lamps), 32'b001001);
        end
        tick();
        chk("clr_mon_lamps", 32'(lamps), 32'b100001);

        // skipped yellow: green straight to red
        drive(G, R);
        set_in(R, R);
        tick();
        chk("skip_fault", 32'(fault), 32'd1);
        chk("skip_code", 32'(fault_code), 32'd3);
        chk("skip_count", 32'(fault_count), 32'd2);
        recover();

        // short yellow: two cycles only
        drive(G, R);
        drive(G, R);
        drive(G, R);
        drive(Y, R);
        drive(Y, R);
        set_in(R, R);
        tick();
        chk("short_fault", 32'(fault), 32'd1);
        chk("short_code", 32'(fault_code), 32'd4);
        chk("short_count", 32'(fault_count), 32'd3);
        recover();

        // conflict, encoding and skipped yellow together: conflict wins
        drive(G, R);
        drive(G, R);
        set_in(G, G);
        tick();
        chk("prio_pre_fault", 32'(fault), 32'd0);
        set_in(OFF, G);
        tick();
        chk("prio_fault", 32'(fault), 32'd1);
        chk("prio_code", 32'(fault_code), 32'd2);
        chk("prio_count", 32'(fault_count), 32'd4);

        // asynchronous reset during the dark flash phase
        repeat (40) tick();
        chk("mid_flash_dark", 32'(lamps), 32'b000000);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_lamps", 32'(lamps), 32'b001001);
        chk("arst_fault", 32'(fault), 32'd0);
        chk("arst_code", 32'(fault_code), 32'd0);
        chk("arst_count", 32'(fault_count), 32'd0);
        set_in(R, R);
        tick();
        rst = 1'b0;
        repeat (16) tick();
        drive(G, R);
        set_in(R, R);
        tick();
        chk("refault_code", 32'(fault_code), 32'd3);
        chk("refault_count", 32'(fault_count), 32'd1);

        // FAULT dwell with no operator clear
`ifdef TRAFFIC_LAMP_MONITOR_AUTO_RECOVER_EN
        repeat (1023) tick();
        chk("dwell_before", 32'(fault), 32'd1);
        tick();
        chk("dwell_exit", 32'(fault), 32'd0);
        chk("dwell_lamps", 32'(lamps), 32'b001001);
`else
        repeat (2000) tick();
        chk("dwell_hold", 32'(fault), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
